spi_port_ctrl: RTL and testbench

Byte-wide SPI host controller answering in the SPI card window ($E9xxxx) that the autoconfig logic assigns. It takes the 68030 bus strobes and the SPI card decode, sequences register reads and writes with its own DSACK termination, and runs an 8-bit mode-0 SPI shift engine with a programmable clock divider and two chip selects. It sits beside the autoconfig block in the CPLD.

---
 rtl/spi_port_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_spi_port_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_port_ctrl
//  Purpose  : 68030 bus slave for the SPI card window with a byte-wide,
//             mode-0 SPI host engine, programmable divider and two chip selects.
//  Revision : 1.0  initial release
// ============================================================================
module spi_port_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic       SEL,
  input  logic [1:0] A,
  input  logic [7:0] D,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       DSACK,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic [1:0] CS_N
);

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ARM  = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_e;

  bus_state_e state_q, state_d;

  logic       as_meta_q, as_s_q, ds_meta_q, ds_s_q;
  logic [1:0] a_q;
  logic       rw_q;
  logic [7:0] d_q;
  logic [7:0] dout_q;
  logic       doe_q, dsack_q;

  logic [7:0] div_q, div_cnt_q, sr_q, rx_q;
  logic [1:0] cs_q;
  logic [2:0] bit_cnt_q;
  logic       ovr_q, busy_q, sclk_q, mosi_q, sample_q;

  logic       capture_d, commit_d, release_d;
  logic       wr_commit, rd_commit;
  logic [7:0] rd_data;

  always_comb begin
    state_d   = state_q;
    capture_d = 1'b0;
    commit_d  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      BUS_IDLE: if (!as_s_q && !SEL) begin
        state_d   = BUS_ARM;
        capture_d = 1'b1;
      end
      // An address strobe that goes away before the data strobe is an abort.
      BUS_ARM: if (as_s_q) begin
        state_d = BUS_IDLE;
      end else if (!ds_s_q) begin
        state_d  = BUS_ACK;
        commit_d = 1'b1;
      end
      BUS_ACK: if (as_s_q) begin
        state_d   = BUS_IDLE;
        release_d = 1'b1;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  assign wr_commit = commit_d & ~rw_q;
  assign rd_commit = commit_d &  rw_q;

  always_comb begin
    rd_data = 8'hFF;
    case (a_q)
      2'd0:    rd_data = rx_q;
      2'd1:    rd_data = {busy_q, ovr_q, 4'b0000, cs_q};
      2'd2:    rd_data = div_q;
      default: rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q   <= BUS_IDLE;
      as_meta_q <= 1'b1;
      as_s_q    <= 1'b1;
      ds_meta_q <= 1'b1;
      ds_s_q    <= 1'b1;
      a_q       <= 2'd0;
      rw_q      <= 1'b1;
      d_q       <= 8'h00;
      dout_q    <= 8'hFF;
      doe_q     <= 1'b0;
      dsack_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      as_meta_q <= AS20;
      as_s_q    <= as_meta_q;
      ds_meta_q <= DS20;
      ds_s_q    <= ds_meta_q;
      if (capture_d) begin
        a_q  <= A;
        rw_q <= RW20;
        d_q  <= D;
      end
      if (commit_d) begin
        dsack_q <= 1'b0;
        doe_q   <= rw_q;
        if (rw_q) dout_q <= rd_data;
      end
      if (release_d) begin
        dsack_q <= 1'b1;
        doe_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      div_q     <= DIV_RESET;
      cs_q      <= 2'b11;
      ovr_q     <= 1'b0;
      rx_q      <= 8'hFF;
      busy_q    <= 1'b0;
      sr_q      <= 8'hFF;
      mosi_q    <= 1'b1;
      sclk_q    <= 1'b0;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      sample_q  <= 1'b0;
    end else begin
      if (busy_q) begin
        if (div_cnt_q == div_q) begin
          div_cnt_q <= 8'd0;
          sclk_q    <= ~sclk_q;
          if (!sclk_q) begin
            sample_q <= MISO;
          end else begin
            sr_q      <= {sr_q[6:0], sample_q};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_q   <= {sr_q[6:0], sample_q};
              busy_q <= 1'b0;
              mosi_q <= 1'b1;
            end else begin
              mosi_q <= sr_q[6];
            end
          end
        end else begin
          div_cnt_q <= div_cnt_q + 8'd1;
        end
      end
      // Engine and a new start never collide: writes while busy are discarded.
      if (wr_commit) begin
        if (busy_q && a_q != 2'd3) begin
          ovr_q <= 1'b1;
        end else begin
          case (a_q)
            2'd0: begin
              sr_q      <= d_q;
              busy_q    <= 1'b1;
              mosi_q    <= d_q[7];
              sclk_q    <= 1'b0;
              div_cnt_q <= 8'd0;
              bit_cnt_q <= 3'd0;
            end
            2'd1:    cs_q  <= d_q[1:0];
            2'd2:    div_q <= d_q;
            default: ;
          endcase
        end
      end else if (rd_commit && a_q == 2'd1) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign DOUT  = dout_q;
  assign DOE   = doe_q;
  assign DSACK = dsack_q;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;
  assign CS_N  = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_port_ctrl
//  Purpose  : Directed plus randomized bench for spi_port_ctrl against a
//             register/transfer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_port_ctrl;

  logic       CLKCPU = 1'b0;
  logic       RESET  = 1'b1;
  logic       AS20   = 1'b1;
  logic       DS20   = 1'b1;
  logic       RW20   = 1'b1;
  logic       SEL    = 1'b1;
  logic [1:0] A      = 2'd0;
  logic [7:0] D      = 8'h00;
  logic [7:0] DOUT;
  logic       DOE, DSACK, SCLK, MOSI, MISO;
  logic [1:0] CS_N;

  logic loop_en = 1'b1;
  logic miso_c  = 1'b0;
  assign MISO = loop_en ? MOSI : miso_c;

  spi_port_ctrl #(.DIV_RESET(8'd3)) dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
    .SEL(SEL), .A(A), .D(D), .DOUT(DOUT), .DOE(DOE), .DSACK(DSACK),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N)
  );

  always #5 CLKCPU = ~CLKCPU;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // SCLK edge log, stamped with the clock edge that produced the change.
  int   rise_q[$];
  int   fall_q[$];
  logic mosi_at_rise[$];
  logic prev_sclk = 1'b0;

  always @(posedge CLKCPU) begin
    cyc++;
    #1;
    if (SCLK !== prev_sclk) begin
      if (SCLK === 1'b1) begin
        rise_q.push_back(cyc);
        mosi_at_rise.push_back(MOSI);
      end else begin
        fall_q.push_back(cyc);
      end
      prev_sclk = SCLK;
    end
  end

  // Reference model state
  logic [7:0] m_div = 8'd3;
  logic [1:0] m_cs  = 2'b11;
  logic [7:0] m_rx  = 8'hFF;
  logic       m_ovr = 1'b0;

  int   last_ack_lat, last_rel_lat, last_commit;
  logic last_doe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    mosi_at_rise.delete();
  endtask

  task automatic bus_cycle(input logic rw, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] q);
    int n;
    @(negedge CLKCPU);
    A = a; D = d; RW20 = rw; SEL = 1'b0; AS20 = 1'b0;
    repeat (2) @(negedge CLKCPU);
    DS20 = 1'b0;
    n = 0;
    while (DSACK !== 1'b0 && n < 20) begin
      @(negedge CLKCPU);
      n++;
    end
    last_ack_lat = n;
    last_commit  = cyc;
    last_doe     = DOE;
    q            = DOUT;
    chk("dsack_assert", {31'd0, DSACK}, 32'd0);
    AS20 = 1'b1; DS20 = 1'b1; SEL = 1'b1;
    n = 0;
    while (DSACK !== 1'b1 && n < 20) begin
      @(negedge CLKCPU);
      n++;
    end
    last_rel_lat = n;
    repeat (2) @(negedge CLKCPU);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused_q;
    bus_cycle(1'b0, a, d, unused_q);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] q;
    bus_cycle(1'b1, a, 8'h00, q);
    chk(tag, {24'd0, q}, {24'd0, exp});
  endtask

  function automatic logic [7:0] status_exp();
    return {1'b0, m_ovr, 4'b0000, m_cs};
  endfunction

  // Waits for a whole byte, then compares timing and MOSI against the model.
  task automatic xfer_check(input logic [7:0] data, input logic [7:0] div, input int commit);
    int n, lim, half, bad;
    logic [7:0] b;
    half = int'(div) + 1;
    lim  = 16 * half + 40;
    n = 0;
    while (fall_q.size() < 8 && n < lim) begin
      @(negedge CLKCPU);
      n++;
    end
    repeat (2) @(negedge CLKCPU);
    chk("sclk_rises", rise_q.size(), 8);
    chk("sclk_falls", fall_q.size(), 8);
    if (rise_q.size() == 8 && fall_q.size() == 8) begin
      chk("first_rise", rise_q[0] - commit, half);
      chk("duration", fall_q[7] - commit, 16 * half);
      bad = 0;
      b   = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (fall_q[i] - rise_q[i] != half) bad++;
        if (i < 7 && rise_q[i+1] - fall_q[i] != half) bad++;
        b = {b[6:0], mosi_at_rise[i]};
      end
      chk("pulse_shape", bad, 0);
      chk("mosi_bits", {24'd0, b}, {24'd0, data});
    end
    chk("mosi_idle", {31'd0, MOSI}, 32'd1);
    chk("sclk_idle", {31'd0, SCLK}, 32'd0);
  endtask

  task automatic start_xfer(input logic [7:0] data, output int commit);
    clear_log();
    wr(2'd0, data);
    commit = last_commit;
  endtask

  initial begin
    int commit, n, lows;
    logic [7:0] data, div;

    // Reset state
    #2 RESET = 1'b0;
    #1;
    chk("rst_dsack", {31'd0, DSACK}, 32'd1);
    chk("rst_doe",   {31'd0, DOE},   32'd0);
    chk("rst_dout",  {24'd0, DOUT},  32'hFF);
    chk("rst_sclk",  {31'd0, SCLK},  32'd0);
    chk("rst_mosi",  {31'd0, MOSI},  32'd1);
    chk("rst_cs",    {30'd0, CS_N},  32'd3);
    repeat (3) @(negedge CLKCPU);
    RESET = 1'b1;
    repeat (2) @(negedge CLKCPU);

    rd_chk("rst_status", 2'd1, status_exp());
    chk("ack_latency", last_ack_lat, 3);
    chk("rel_latency", last_rel_lat, 3);
    chk("doe_on_read", {31'd0, last_doe}, 32'd1);
    chk("doe_released", {31'd0, DOE}, 32'd0);
    rd_chk("rst_div", 2'd2, m_div);

    // Chip select then a looped-back A5 transfer at DIV 3
    wr(2'd1, 8'h02);
    m_cs = 2'b10;
    chk("doe_on_write", {31'd0, last_doe}, 32'd0);
    chk("cs_pins", {30'd0, CS_N}, {30'd0, m_cs});
    start_xfer(8'hA5, commit);
    xfer_check(8'hA5, m_div, commit);
    m_rx = 8'hA5;
    rd_chk("rx_a5", 2'd0, m_rx);

    // Overrun: write while busy is terminated and discarded
    start_xfer(8'h5A, commit);
    wr(2'd0, 8'h3C);
    m_ovr = 1'b1;
    xfer_check(8'h5A, m_div, commit);
    m_rx = 8'h5A;
    rd_chk("rx_after_ovr", 2'd0, m_rx);
    rd_chk("status_ovr_set", 2'd1, status_exp());
    m_ovr = 1'b0;
    rd_chk("status_ovr_clr", 2'd1, status_exp());

    // Aborted cycle: AS withdrawn before DS
    @(negedge CLKCPU);
    A = 2'd2; D = 8'h77; RW20 = 1'b0; SEL = 1'b0; AS20 = 1'b0;
    repeat (4) @(negedge CLKCPU);
    AS20 = 1'b1; SEL = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLKCPU);
      if (DSACK !== 1'b1) lows++;
    end
    chk("abort_no_dsack", lows, 0);
    rd_chk("abort_div", 2'd2, m_div);

    // Randomized divider / data transfers with loopback
    for (int it = 0; it < 4; it++) begin
      div  = 8'($urandom_range(0, 6));
      data = 8'($urandom);
      wr(2'd2, div);
      m_div = div;
      rd_chk("rand_div", 2'd2, m_div);
      start_xfer(data, commit);
      xfer_check(data, m_div, commit);
      m_rx = data;
      rd_chk("rand_rx", 2'd0, m_rx);
      wr(2'd3, 8'($urandom));
      rd_chk("reserved", 2'd3, 8'hFF);
    end

    // Divider extremes with MISO held high
    loop_en = 1'b0;
    miso_c  = 1'b1;
    wr(2'd2, 8'd0);
    m_div = 8'd0;
    start_xfer(8'h00, commit);
    xfer_check(8'h00, m_div, commit);
    m_rx = 8'hFF;
    rd_chk("div0_rx", 2'd0, m_rx);
    wr(2'd2, 8'd255);
    m_div = 8'd255;
    data = 8'($urandom);
    start_xfer(data, commit);
    xfer_check(data, m_div, commit);
    rd_chk("div255_rx", 2'd0, m_rx);

    // Reset in the middle of a transfer
    loop_en = 1'b1;
    wr(2'd2, 8'd3);
    m_div = 8'd3;
    start_xfer(8'hC3, commit);
    n = 0;
    while (rise_q.size() + fall_q.size() < 3 && n < 200) begin
      @(negedge CLKCPU);
      n++;
    end
    chk("third_edge_seen", {31'd0, (rise_q.size() + fall_q.size() >= 3)}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("midrst_sclk", {31'd0, SCLK}, 32'd0);
    chk("midrst_mosi", {31'd0, MOSI}, 32'd1);
    chk("midrst_cs",   {30'd0, CS_N}, 32'd3);
    m_div = 8'd3; m_cs = 2'b11; m_rx = 8'hFF; m_ovr = 1'b0;
    repeat (2) @(negedge CLKCPU);
    RESET = 1'b1;
    repeat (2) @(negedge CLKCPU);
    rd_chk("midrst_status", 2'd1, status_exp());
    rd_chk("midrst_rx", 2'd0, m_rx);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
